// File: rtl/vram_write_queue.sv
// Posted-write FIFO that drains snooped CPU framebuffer writes into VRAM
// inside a fixed 3-clock window phased against the video fetch sequence.
module vram_write_queue #(
    parameter int         DEPTH   = 8,
    parameter logic [2:0] WR_SLOT = 3'd4
) (
    input  logic                   pixClk,
    input  logic                   Reset,
    input  logic [2:0]             seq,
    input  logic                   wrReq,
    input  logic [14:0]            wrAddr,
    input  logic [7:0]             wrData,
    input  logic                   wrBuf,
    output logic [14:0]            vramAddr,
    output logic [7:0]             vramData,
    output logic                   vramDataOE,
    output logic                   nvramWE,
    output logic                   nvramCE0,
    output logic                   nvramCE1,
    output logic                   wrBusy,
    output logic [$clog2(DEPTH):0] fifoCount,
    output logic                   fifoEmpty,
    output logic                   fifoFull,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t          state, state_nxt;
    logic [23:0]     mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [AW:0]     count_nxt;
    logic [23:0]     head;
    logic            push, pop;

    assign head   = mem[rd_ptr];
    // The entry leaves the FIFO only once the bus cycle is complete.
    assign pop    = (state == HOLD);
    assign push   = wrReq && (!fifoFull || pop);
    assign wrBusy = (state != IDLE);

    always_ff @(posedge pixClk) begin
        if (push)
            mem[wr_ptr] <= {wrBuf, wrAddr, wrData};
    end

    always_comb begin
        count_nxt = fifoCount;
        if (push && !pop)
            count_nxt = fifoCount + 1'b1;
        else if (pop && !push)
            count_nxt = fifoCount - 1'b1;
    end

    always_ff @(posedge pixClk or posedge Reset) begin
        if (Reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fifoCount <= '0;
            fifoEmpty <= 1'b1;
            fifoFull  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifoCount <= count_nxt;
            fifoEmpty <= (count_nxt == '0);
            fifoFull  <= (count_nxt == FULL_CNT);
            if (wrReq && !push)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge pixClk or posedge Reset) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifoEmpty && seq == WR_SLOT) state_nxt = SETUP;
            SETUP:   state_nxt = STROBE;
            STROBE:  state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus pins are registered off the next state so they line up with it;
    // address, data and CE are captured once in SETUP and held through HOLD.
    always_ff @(posedge pixClk or posedge Reset) begin
        if (Reset) begin
            vramAddr   <= '0;
            vramData   <= '0;
            vramDataOE <= 1'b0;
            nvramWE    <= 1'b1;
            nvramCE0   <= 1'b1;
            nvramCE1   <= 1'b1;
        end else begin
            case (state_nxt)
                SETUP: begin
                    vramAddr   <= head[22:8];
                    vramData   <= head[7:0];
                    vramDataOE <= 1'b1;
                    nvramWE    <= 1'b1;
                    nvramCE0   <= head[23];
                    nvramCE1   <= !head[23];
                end
                STROBE:  nvramWE <= 1'b0;
                HOLD:    nvramWE <= 1'b1;
                default: begin
                    vramDataOE <= 1'b0;
                    nvramWE    <= 1'b1;
                    nvramCE0   <= 1'b1;
                    nvramCE1   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_write_queue.sv
// Directed + random bench for vram_write_queue; a queue-based model predicts
// every bus pin and FIFO flag each clock.
module tb_vram_write_queue;

    localparam int         DEPTH   = 8;
    localparam logic [2:0] WR_SLOT = 3'd4;
    localparam logic [2:0] WE_SEQ  = WR_SLOT + 3'd2;

    logic        pixClk = 1'b0;
    logic        Reset  = 1'b1;
    logic [2:0]  seq    = '0;
    logic        wrReq  = 1'b0;
    logic [14:0] wrAddr = '0;
    logic [7:0]  wrData = '0;
    logic        wrBuf  = 1'b0;
    logic [14:0] vramAddr;
    logic [7:0]  vramData;
    logic        vramDataOE, nvramWE, nvramCE0, nvramCE1, wrBusy;
    logic [3:0]  fifoCount;
    logic        fifoEmpty, fifoFull, overflow;

    vram_write_queue #(.DEPTH(DEPTH), .WR_SLOT(WR_SLOT)) dut (
        .pixClk(pixClk), .Reset(Reset), .seq(seq), .wrReq(wrReq),
        .wrAddr(wrAddr), .wrData(wrData), .wrBuf(wrBuf),
        .vramAddr(vramAddr), .vramData(vramData), .vramDataOE(vramDataOE),
        .nvramWE(nvramWE), .nvramCE0(nvramCE0), .nvramCE1(nvramCE1),
        .wrBusy(wrBusy), .fifoCount(fifoCount), .fifoEmpty(fifoEmpty),
        .fifoFull(fifoFull), .overflow(overflow)
    );

    always #5 pixClk = ~pixClk;

    int vectors     = 0;
    int miscompares = 0;

    // Model: pending entries, sticky drop flag, and how far into the
    // 3-clock bus window we are (0 = not writing).
    logic [23:0] m_q[$];
    bit          m_ovf;
    int          m_phase;
    logic [14:0] m_addr;
    logic [7:0]  m_data;
    logic        m_buf;
    logic [2:0]  seq_cnt = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf   = 1'b0;
        m_phase = 0;
        m_addr  = '0;
        m_data  = '0;
        m_buf   = 1'b0;
    endtask

    task automatic model_edge(input logic req, input logic [23:0] ent, input logic [2:0] s);
        bit pop, full;
        pop  = (m_phase == 3);
        full = (m_q.size() == DEPTH);
        if (pop) begin
            void'(m_q.pop_front());
            m_phase = 0;
        end else if (m_phase != 0) begin
            m_phase++;
        end else if (m_q.size() != 0 && s == WR_SLOT) begin
            m_phase = 1;
            {m_buf, m_addr, m_data} = m_q[0];
        end
        if (req) begin
            if (!full || pop) m_q.push_back(ent);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic check_all();
        bit act;
        act = (m_phase != 0);
        chk("vramAddr",   vramAddr,   m_addr);
        chk("vramData",   vramData,   m_data);
        chk("vramDataOE", vramDataOE, act);
        chk("nvramWE",    nvramWE,    !(m_phase == 2));
        chk("nvramCE0",   nvramCE0,   !(act && !m_buf));
        chk("nvramCE1",   nvramCE1,   !(act && m_buf));
        chk("wrBusy",     wrBusy,     act);
        chk("fifoCount",  fifoCount,  m_q.size());
        chk("fifoEmpty",  fifoEmpty,  m_q.size() == 0);
        chk("fifoFull",   fifoFull,   m_q.size() == DEPTH);
        chk("overflow",   overflow,   m_ovf);
        chk("ce_exclusive", nvramCE0 | nvramCE1, 1);
        if (nvramWE === 1'b0) chk("we_slot", seq_cnt, WE_SEQ);
    endtask

    task automatic tick(input logic req, input logic [14:0] a, input logic [7:0] d, input logic b);
        seq = seq_cnt; wrReq = req; wrAddr = a; wrData = d; wrBuf = b;
        @(posedge pixClk);
        model_edge(req, {b, a, d}, seq_cnt);
        seq_cnt = seq_cnt + 3'd1;
        @(negedge pixClk);
        wrReq = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            tick(1'b0, 15'($urandom), 8'($urandom), 1'($urandom));
    endtask

    task automatic push_rand(input logic b);
        tick(1'b1, 15'($urandom), 8'($urandom), b);
    endtask

    task automatic wait_seq(input logic [2:0] s);
        while (seq_cnt != s) idle(1);
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < 40 && m_phase != ph; i++) idle(1);
        chk("wait_busy", wrBusy, 1);
    endtask

    task automatic reset_dut();
        Reset = 1'b1;
        #1;
        model_reset();
        chk("rst_async_we",  nvramWE,  1);
        chk("rst_async_ce0", nvramCE0, 1);
        chk("rst_async_ce1", nvramCE1, 1);
        chk("rst_async_cnt", fifoCount, 0);
        for (int i = 0; i < 2; i++) begin
            seq = seq_cnt;
            @(posedge pixClk);
            seq_cnt = seq_cnt + 3'd1;
            @(negedge pixClk);
        end
        Reset = 1'b0;
        check_all();
    endtask

    initial begin
        model_reset();
        @(negedge pixClk);
        reset_dut();
        idle(3);

        // Single write at seq=1 to CE0
        wait_seq(3'd1);
        tick(1'b1, 15'h1234, 8'hA5, 1'b0);
        idle(12);

        // Burst of 9 starting right after the write slot: last one is dropped
        wait_seq(WR_SLOT + 3'd1);
        for (int i = 0; i < 9; i++) push_rand(1'($urandom));
        idle(70);

        // Full FIFO, push lands on the pop edge
        reset_dut();
        wait_seq(WR_SLOT + 3'd1);
        for (int i = 0; i < 8; i++) push_rand(1'($urandom));
        wait_phase(3);
        push_rand(1'b1);
        idle(75);

        // Alternating buffer select
        for (int i = 0; i < 4; i++) begin
            push_rand(1'(i));
            idle($urandom_range(0, 9));
        end
        idle(30);

        // Reset while WE is low
        push_rand(1'b1);
        push_rand(1'b0);
        wait_phase(2);
        chk("mid_strobe_we", nvramWE, 0);
        #1;
        reset_dut();
        idle(10);

        // Push phase sweep over every seq value
        for (int p = 0; p < 8; p++) begin
            wait_seq(3'(p));
            push_rand(1'($urandom));
            idle(20);
        end

        // Random traffic, including overflow pressure
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) push_rand(1'($urandom));
            else idle(1);
        end
        idle(80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
